// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the data cache, bundled for port hookup.
interface dcache_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              cpu_req_i;
  logic              cpu_write_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  // Cache side.
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // Pipeline plus memory side.
  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache. Hits finish in the
// access cycle; misses stall the pipeline while a line is written back and/or
// fetched over a level-enable / pulse-ack memory handshake.
module dcache_controller #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int LINE_W   = 8 * LINE_BYTES;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [LINE_W-1:0]    data_arr [NUM_LINES];

  // Miss address captured at miss time so a mid-miss flush cannot corrupt the fill.
  logic [TAG_W-1:0]     miss_tag;
  logic [INDEX_W-1:0]   miss_idx;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_idx;
  logic [WORD_W-1:0]    req_word;
  logic                 hit, store_hit, fill;

  assign req_tag  = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_word = bus.cpu_addr_i[2 +: WORD_W];

  assign hit       = bus.cpu_req_i & valid[req_idx] & (tag_arr[req_idx] == req_tag);
  assign store_hit = hit & bus.cpu_write_i & (state == IDLE);
  assign fill      = (state == ALLOCATE) & bus.mem_ack_i;

  assign bus.cpu_stall_o = bus.cpu_req_i & (~hit | (state != IDLE));
  assign bus.cpu_data_o  = (hit & ~bus.cpu_write_i)
                         ? data_arr[req_idx][32*int'(req_word) +: 32] : '0;

  // Tag/data storage: line fill from memory, or single-word store on a hit.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_arr[miss_idx] <= bus.mem_data_i;
      tag_arr[miss_idx]  <= miss_tag;
    end else if (store_hit) begin
      data_arr[req_idx][32*int'(req_word) +: 32] <= bus.cpu_data_i;
    end
  end

  // Miss FSM with registered memory-side outputs and per-line valid/dirty bits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      valid            <= '0;
      dirty            <= '0;
      miss_tag         <= '0;
      miss_idx         <= '0;
      bus.mem_enable_o <= 1'b0;
      bus.mem_write_o  <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_i & ~hit) begin
            miss_tag         <= req_tag;
            miss_idx         <= req_idx;
            bus.mem_enable_o <= 1'b1;
            if (valid[req_idx] & dirty[req_idx]) begin
              state           <= WRITEBACK;
              bus.mem_write_o <= 1'b1;
              bus.mem_addr_o  <= {tag_arr[req_idx], req_idx, {OFFSET_W{1'b0}}};
              bus.mem_data_o  <= data_arr[req_idx];
            end else begin
              state           <= ALLOCATE;
              bus.mem_write_o <= 1'b0;
              bus.mem_addr_o  <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
            end
          end else if (store_hit) begin
            dirty[req_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          // Enable stays high straight into the fetch; only direction and address change.
          if (bus.mem_ack_i) begin
            state           <= ALLOCATE;
            bus.mem_write_o <= 1'b0;
            bus.mem_addr_o  <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            state            <= REFILL;
            bus.mem_enable_o <= 1'b0;
            valid[miss_idx]  <= 1'b1;
            dirty[miss_idx]  <= 1'b0;
          end
        end
        REFILL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: reset, clean/dirty misses with slow and
// zero-wait memory, store hits, store miss, and reset during a line fetch.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if bus ();
  dcache_controller dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0;

  // Memory model: word-addressed store, unwritten words read as line_addr | word.
  logic [31:0] mem_w [int unsigned];

  // Results of the last access.
  int           extra;
  logic [31:0]  rdata;
  logic         mem_seen, wb_seen, done;
  logic         first_wr;
  logic [31:0]  first_addr, wb_addr;
  logic [255:0] wb_line;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      int unsigned wa = la + 32'(w * 4);
      l[w*32 +: 32] = mem_w.exists(wa) ? mem_w[wa] : (la | 32'(w));
    end
    return l;
  endfunction

  // One pipeline access; memory acks after wt extra enable cycles in each state.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input int wt);
    int cnt = 0;
    int stalls = 0;
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_write_i = wr; bus.cpu_addr_i = a; bus.cpu_data_i = d;
    bus.mem_ack_i = 1'b0;
    mem_seen = 0; wb_seen = 0; done = 0; rdata = '0;
    first_wr = 0; first_addr = '0; wb_addr = '0; wb_line = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (!bus.cpu_stall_o) begin
        rdata = bus.cpu_data_o; done = 1; break;
      end
      stalls++;
      if (bus.mem_enable_o) begin
        if (!mem_seen) begin first_wr = bus.mem_write_o; first_addr = bus.mem_addr_o; end
        mem_seen = 1;
        if (bus.mem_write_o) begin wb_seen = 1; wb_addr = bus.mem_addr_o; wb_line = bus.mem_data_o; end
        if (cnt == wt) begin
          cnt = 0;
          bus.mem_ack_i = 1'b1;
          if (bus.mem_write_o)
            for (int w = 0; w < 8; w++) mem_w[bus.mem_addr_o + 32'(w*4)] = bus.mem_data_o[w*32 +: 32];
          else
            bus.mem_data_i = mem_line(bus.mem_addr_o);
        end else cnt++;
      end
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
    end
    extra = (stalls == 0) ? 0 : stalls - 1;
    chk("access_done", 256'(done), 256'(1));
    @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
  endtask

  initial begin
    mem_w[32'h48] = 32'hDEADBEEF;
    bus.cpu_req_i = 0; bus.cpu_write_i = 0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    bus.mem_data_i = '0; bus.mem_ack_i = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enable", 256'(bus.mem_enable_o), 256'(0));
    chk("rst_write",  256'(bus.mem_write_o), 256'(0));
    chk("rst_stall",  256'(bus.cpu_stall_o), 256'(0));
    chk("rst_data",   256'(bus.cpu_data_o), 256'(0));
    @(negedge clk); rst_n = 1;

    // First load after reset misses clean and heads straight to a fetch.
    @(negedge clk);
    bus.cpu_req_i = 1; bus.cpu_write_i = 0; bus.cpu_addr_i = 32'h40;
    #1;
    chk("miss_stall", 256'(bus.cpu_stall_o), 256'(1));
    @(negedge clk); #1;
    chk("alloc_enable", 256'(bus.mem_enable_o), 256'(1));
    chk("alloc_write",  256'(bus.mem_write_o), 256'(0));
    chk("alloc_addr",   256'(bus.mem_addr_o), 256'(32'h40));
    // Reset in the middle of the fetch drops enable at once.
    rst_n = 0; #1;
    chk("rst_mid_enable", 256'(bus.mem_enable_o), 256'(0));
    chk("rst_mid_stall",  256'(bus.cpu_stall_o), 256'(1));
    bus.cpu_req_i = 0;
    @(negedge clk); rst_n = 1;

    // Clean miss, ack in 3rd fetch cycle: line was invalidated, so it misses again.
    access(0, 32'h48, 0, 2);
    chk("clean_extra", 256'(extra), 256'(4));
    chk("clean_data",  256'(rdata), 256'(32'hDEADBEEF));
    chk("clean_nowb",  256'(wb_seen), 256'(0));
    chk("clean_addr",  256'(first_addr), 256'(32'h40));

    // Store hit: no stall, no memory traffic; read back.
    access(1, 32'h4C, 32'h12345678, 0);
    chk("st_hit_extra", 256'(extra), 256'(0));
    chk("st_hit_nomem", 256'(mem_seen), 256'(0));
    access(0, 32'h4C, 0, 0);
    chk("ld_after_st", 256'(rdata), 256'(32'h12345678));

    // Dirty eviction of index 2.
    access(0, 32'h240, 0, 2);
    chk("dirty_wb_first", 256'(first_wr), 256'(1));
    chk("dirty_wb_addr",  256'(wb_addr), 256'(32'h40));
    chk("dirty_wb_w3",    256'(wb_line[127:96]), 256'(32'h12345678));
    chk("dirty_wb_w2",    256'(wb_line[95:64]), 256'(32'hDEADBEEF));
    chk("dirty_extra",    256'(extra), 256'(7));
    chk("dirty_data",     256'(rdata), 256'(32'h240));

    // Zero-wait memory on index 0.
    access(0, 32'h1000, 0, 0);
    chk("zw_clean_extra", 256'(extra), 256'(2));
    chk("zw_clean_data",  256'(rdata), 256'(32'h1000));
    access(1, 32'h1004, 32'hAAAA5555, 0);
    chk("zw_st_extra", 256'(extra), 256'(0));
    access(0, 32'h2004, 0, 0);
    chk("zw_dirty_extra", 256'(extra), 256'(3));
    chk("zw_dirty_wbaddr", 256'(wb_addr), 256'(32'h1000));
    chk("zw_dirty_wbw1", 256'(wb_line[63:32]), 256'(32'hAAAA5555));
    chk("zw_dirty_data", 256'(rdata), 256'(32'h2001));

    // Refetch of the written-back line returns the stored word.
    access(0, 32'h1004, 0, 1);
    chk("refetch_extra", 256'(extra), 256'(3));
    chk("refetch_data",  256'(rdata), 256'(32'hAAAA5555));

    // Store miss allocates, then writes after refill.
    access(1, 32'h3008, 32'h11112222, 0);
    chk("st_miss_extra", 256'(extra), 256'(2));
    chk("st_miss_nowb",  256'(wb_seen), 256'(0));
    access(0, 32'h3008, 0, 0);
    chk("st_miss_rd_extra", 256'(extra), 256'(0));
    chk("st_miss_rd_data",  256'(rdata), 256'(32'h11112222));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
